arith_request_sequencer: RTL and testbench

Initiator and collector for the pipelined arithmetic host. It accepts tagged operation commands over a valid/ready interface and issues them to the host's fire-and-forget operand port (a/b/op/valid). It matches the in-order results returned by the host to their tags and buffers them in a response FIFO with valid/ready. The host has no backpressure, so the sequencer admits a command only when response buffering is guaranteed for every operation in flight.

---
 rtl/arith_request_sequencer.sv | 176 +++++++++++++++++
 tb/tb_arith_request_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_request_sequencer.sv
// arith_request_sequencer: issues tagged commands to the fire-and-forget
// arithmetic host and collects its in-order results into a response FIFO.
// A command is admitted only when a response slot is already reserved for
// every operation in flight, because the host cannot be stalled.
module arith_request_sequencer #(
  parameter int RSP_DEPTH = 8,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      host_a,
  output logic [15:0]      host_b,
  output logic [1:0]       host_op,
  output logic             host_valid,
  input  logic [15:0]      host_res,
  input  logic             host_res_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [4:0]       inflight,
  output logic             err_orphan,
  output logic             err_timeout
);

  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam int WW  = $clog2(TIMEOUT + 1);
  localparam logic [CW:0]   DEPTH_C   = CW1'(RSP_DEPTH);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  // Issue registers towards the host
  logic [15:0] host_a_reg;
  logic [15:0] host_b_reg;
  logic [1:0]  host_op_reg;
  logic        host_valid_reg;

  // Tag queue: tags of issued commands awaiting their results
  logic [TAG_W-1:0] tag_mem [RSP_DEPTH];
  logic [PW-1:0]    tq_wr_ptr_reg;
  logic [PW-1:0]    tq_rd_ptr_reg;

  // Response FIFO storage and pointers
  logic [15:0]      rsp_dmem [RSP_DEPTH];
  logic [TAG_W-1:0] rsp_tmem [RSP_DEPTH];
  logic [PW-1:0]    rf_wr_ptr_reg;
  logic [PW-1:0]    rf_rd_ptr_reg;

  logic [CW-1:0] fifo_count_reg, fifo_count_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [WW-1:0] wd_reg, wd_next;
  logic          err_orphan_reg;
  logic          err_timeout_reg;

  logic [CW:0]      credit_used;
  logic             accept;
  logic             has_inflight;
  logic             ret_ok;
  logic             orphan;
  logic             pop;
  logic [TAG_W-1:0] popped_tag;

  // Credit: every in-flight op plus every buffered response holds one slot
  always_comb begin
    credit_used = {1'b0, fifo_count_reg} + {1'b0, inflight_reg};
  end

  assign cmd_ready    = credit_used < DEPTH_C;
  assign accept       = cmd_valid && cmd_ready;
  assign has_inflight = inflight_reg != '0;
  assign ret_ok       = host_res_valid && has_inflight;
  assign orphan       = host_res_valid && !has_inflight;
  assign rsp_valid    = fifo_count_reg != '0;
  assign pop          = rsp_valid && rsp_ready;
  assign popped_tag   = tag_mem[tq_rd_ptr_reg];

  // Output image of the state; an empty FIFO shows zeros
  assign host_a      = host_a_reg;
  assign host_b      = host_b_reg;
  assign host_op     = host_op_reg;
  assign host_valid  = host_valid_reg;
  assign rsp_data    = rsp_valid ? rsp_dmem[rf_rd_ptr_reg] : '0;
  assign rsp_tag     = rsp_valid ? rsp_tmem[rf_rd_ptr_reg] : '0;
  assign inflight    = 5'(inflight_reg);
  assign err_orphan  = err_orphan_reg;
  assign err_timeout = err_timeout_reg;

  // Occupancy bookkeeping; simultaneous inc/dec cancel out
  always_comb begin
    inflight_next   = inflight_reg;
    fifo_count_next = fifo_count_reg;
    case ({accept, ret_ok})
      2'b10:   inflight_next = inflight_reg + CW'(1);
      2'b01:   inflight_next = inflight_reg - CW'(1);
      default: inflight_next = inflight_reg;
    endcase
    case ({ret_ok, pop})
      2'b10:   fifo_count_next = fifo_count_reg + CW'(1);
      2'b01:   fifo_count_next = fifo_count_reg - CW'(1);
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  // Watchdog: counts result-less cycles while work is outstanding, saturating
  always_comb begin
    wd_next = wd_reg;
    if (host_res_valid || !has_inflight) begin
      wd_next = '0;
    end else if (wd_reg != TIMEOUT_C) begin
      wd_next = wd_reg + WW'(1);
    end
  end

  // Storage writes: tag on accept, result+tag on a matched return
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tq_wr_ptr_reg] <= cmd_tag;
    end
    if (ret_ok) begin
      rsp_dmem[rf_wr_ptr_reg] <= host_res;
      rsp_tmem[rf_wr_ptr_reg] <= popped_tag;
    end
  end

  // Control state, issue registers and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_a_reg      <= '0;
      host_b_reg      <= '0;
      host_op_reg     <= '0;
      host_valid_reg  <= 1'b0;
      tq_wr_ptr_reg   <= '0;
      tq_rd_ptr_reg   <= '0;
      rf_wr_ptr_reg   <= '0;
      rf_rd_ptr_reg   <= '0;
      fifo_count_reg  <= '0;
      inflight_reg    <= '0;
      wd_reg          <= '0;
      err_orphan_reg  <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      host_valid_reg <= accept;
      if (accept) begin
        host_a_reg    <= cmd_a;
        host_b_reg    <= cmd_b;
        host_op_reg   <= cmd_op;
        tq_wr_ptr_reg <= tq_wr_ptr_reg + PW'(1);
      end
      if (ret_ok) begin
        tq_rd_ptr_reg <= tq_rd_ptr_reg + PW'(1);
        rf_wr_ptr_reg <= rf_wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rf_rd_ptr_reg <= rf_rd_ptr_reg + PW'(1);
      end
      fifo_count_reg <= fifo_count_next;
      inflight_reg   <= inflight_next;
      wd_reg         <= wd_next;
      if (orphan) begin
        err_orphan_reg <= 1'b1;
      end
      if (wd_next == TIMEOUT_C) begin
        err_timeout_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arith_request_sequencer.sv
// Bench for arith_request_sequencer: a 4-stage model host plus a queue-based
// reference of commands in flight and responses awaiting the consumer.
module tb_arith_request_sequencer;

  localparam int TAG_W = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [15:0]      cmd_a = '0;
  logic [15:0]      cmd_b = '0;
  logic [1:0]       cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [15:0]      host_a;
  logic [15:0]      host_b;
  logic [1:0]       host_op;
  logic             host_valid;
  logic [15:0]      host_res;
  logic             host_res_valid;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [4:0]       inflight;
  logic             err_orphan;
  logic             err_timeout;

  arith_request_sequencer #(.RSP_DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .host_a(host_a), .host_b(host_b), .host_op(host_op), .host_valid(host_valid),
    .host_res(host_res), .host_res_valid(host_res_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .inflight(inflight), .err_orphan(err_orphan), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [1:0] op);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      2'd0:    return 16'(32'(a) + 32'(b));
      2'd1:    return 16'(32'(a) - 32'(b));
      2'd2:    return p[15:0];
      default: return a & b;
    endcase
  endfunction

  // Model host: 3 pipeline stages plus output register; can swallow ops or inject results
  logic        host_mute = 1'b0;
  logic        force_v = 1'b0;
  logic [15:0] force_d = '0;
  logic [3:0]  hv_pipe;
  logic [15:0] hd0, hd1, hd2, hd3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_pipe <= '0;
      hd0 <= '0; hd1 <= '0; hd2 <= '0; hd3 <= '0;
    end else begin
      hv_pipe <= {hv_pipe[2:0], host_valid & ~host_mute};
      hd0 <= alu(host_a, host_b, host_op);
      hd1 <= hd0; hd2 <= hd1; hd3 <= hd2;
    end
  end
  assign host_res_valid = hv_pipe[3] | force_v;
  assign host_res       = force_v ? force_d : hd3;

  // Reference model: ops issued but not returned, and responses not yet consumed
  typedef struct packed {
    logic [15:0]      d;
    logic [TAG_W-1:0] t;
  } ent_t;
  ent_t m_pend[$];
  ent_t m_rsp[$];
  bit   m_orphan = 1'b0;
  bit   m_timeout = 1'b0;
  int   m_wd = 0;

  bit s_acc, s_pop, s_ret, s_idle;
  ent_t s_ent;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pend.delete();
    m_rsp.delete();
    m_orphan = 1'b0;
    m_timeout = 1'b0;
    m_wd = 0;
  endtask

  task automatic chk_all();
    chk("cmd_ready", 32'(cmd_ready), 32'((m_pend.size() + m_rsp.size()) < DEPTH));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp.size() != 0));
    if (m_rsp.size() != 0) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp[0].d));
      chk("rsp_tag", 32'(rsp_tag), 32'(m_rsp[0].t));
    end
    chk("inflight", 32'(inflight), 32'(m_pend.size()));
    chk("err_orphan", 32'(err_orphan), 32'(m_orphan));
    chk("err_timeout", 32'(err_timeout), 32'(m_timeout));
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({pfx, "_host_a"}, 32'(host_a), 32'd0);
    chk({pfx, "_host_b"}, 32'(host_b), 32'd0);
    chk({pfx, "_host_op"}, 32'(host_op), 32'd0);
    chk({pfx, "_host_valid"}, 32'(host_valid), 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({pfx, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
    chk({pfx, "_inflight"}, 32'(inflight), 32'd0);
    chk({pfx, "_err_orphan"}, 32'(err_orphan), 32'd0);
    chk({pfx, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // Mid-cycle: compare against the model and capture what the coming edge will see
  task automatic sample();
    @(negedge clk);
    chk_all();
    s_acc  = cmd_valid && ((m_pend.size() + m_rsp.size()) < DEPTH);
    s_pop  = rsp_ready && (m_rsp.size() != 0);
    s_ret  = host_res_valid;
    s_idle = (m_pend.size() == 0);
    s_ent  = '{d: alu(cmd_a, cmd_b, cmd_op), t: cmd_tag};
  endtask

  // Clock edge: advance the model, then release inputs for change
  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      if (s_pop) e = m_rsp.pop_front();
      if (s_ret) begin
        if (s_idle) m_orphan = 1'b1;
        else m_rsp.push_back(m_pend.pop_front());
      end
      if (s_acc) m_pend.push_back(s_ent);
      if (s_ret || s_idle) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd >= 15) m_timeout = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_cmd(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] t);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = t;
  endtask

  logic [15:0] mx_d [3];

  initial begin
    mx_d[0] = 16'hFFFE; mx_d[1] = 16'h0000; mx_d[2] = 16'h00F0;

    // Reset state
    advance(); advance();
    @(negedge clk);
    chk_rst("reset");
    advance();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Single add: issue registers, then response 6 cycles on (accept cycle = 0)
    rsp_ready = 1'b1;
    set_cmd(16'h1234, 16'h0101, 2'b00, 4'd3);
    cyc();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      sample();
      if (k == 1) begin
        chk("single_host_valid", 32'(host_valid), 32'd1);
        chk("single_host_a", 32'(host_a), 32'h1234);
        chk("single_host_b", 32'(host_b), 32'h0101);
        chk("single_host_op", 32'(host_op), 32'd0);
      end
      chk("single_latency", 32'(rsp_valid), 32'(k == 6));
      if (k == 6) begin
        chk("single_data", 32'(rsp_data), 32'h1335);
        chk("single_tag", 32'(rsp_tag), 32'd3);
        chk("single_inflight", 32'(inflight), 32'd0);
      end
      advance();
    end
    cyc();

    // Mixed ops streaming back-to-back
    set_cmd(16'h0005, 16'h0007, 2'b01, 4'd5); cyc();
    set_cmd(16'h0100, 16'h0100, 2'b10, 4'd6); cyc();
    set_cmd(16'hF0F0, 16'h0FF0, 2'b11, 4'd7); cyc();
    cmd_valid = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      sample();
      chk("mix_valid", 32'(rsp_valid), 32'(k >= 6 && k <= 8));
      if (k >= 6 && k <= 8) begin
        chk("mix_data", 32'(rsp_data), 32'(mx_d[k-6]));
        chk("mix_tag", 32'(rsp_tag), 32'(k - 1));
      end
      advance();
    end

    // Credit stall: consumer stopped, ten commands offered
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_cmd(16'($urandom), 16'($urandom), 2'($urandom), 4'(i));
      sample();
      chk("stall_ready", 32'(cmd_ready), 32'(i < DEPTH));
      advance();
    end
    cmd_valid = 1'b0;
    repeat (6) cyc();
    sample();
    chk("stall_full_ready", 32'(cmd_ready), 32'd0);
    chk("stall_full_inflight", 32'(inflight), 32'd0);
    advance();
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      chk("stall_tag_order", 32'(rsp_tag), 32'(i));
      advance();
    end
    sample();
    chk("stall_drained_ready", 32'(cmd_ready), 32'd1);
    chk("stall_drained_valid", 32'(rsp_valid), 32'd0);
    advance();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 70);
      cmd_a     = 16'($urandom);
      cmd_b     = 16'($urandom);
      cmd_op    = 2'($urandom);
      cmd_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 60);
      cyc();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (14) cyc();

    // Orphan result with nothing in flight
    force_v = 1'b1; force_d = 16'hBEEF;
    cyc();
    force_v = 1'b0;
    repeat (3) begin
      sample();
      chk("orphan_sticky", 32'(err_orphan), 32'd1);
      chk("orphan_no_rsp", 32'(rsp_valid), 32'd0);
      advance();
    end

    // Timeout: host swallows the op, result delivered late
    host_mute = 1'b1;
    set_cmd(16'h0001, 16'h0002, 2'b00, 4'd9);
    cyc();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sample();
      chk("timeout_flag", 32'(err_timeout), 32'(k >= 16));
      advance();
    end
    host_mute = 1'b0;
    force_v = 1'b1; force_d = 16'h0003;
    cyc();
    force_v = 1'b0;
    sample();
    chk("late_valid", 32'(rsp_valid), 32'd1);
    chk("late_tag", 32'(rsp_tag), 32'd9);
    chk("late_inflight", 32'(inflight), 32'd0);
    chk("late_timeout_sticky", 32'(err_timeout), 32'd1);
    advance();
    repeat (3) cyc();

    // Reset with three ops in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(16'($urandom), 16'($urandom), 2'($urandom), 4'(i + 1));
      cyc();
    end
    cmd_valid = 1'b0;
    sample();
    chk("pre_rst_inflight", 32'(inflight), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("midrst");
    m_reset();
    advance(); advance();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
